wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: BUS_WIDTH, default 32, datapath width (minimum 16, multiple of 8).
REQ-002 Parameter: REG_ADDR_WIDTH, default 5, register-file address width.
REQ-003 Port: i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: i_reset  input  1  synchronous, active-high reset.
REQ-005 Port: i_halt  input  1  stage stall; hold all state.
REQ-006 Port: i_flush  input  1  load a bubble instead of the incoming instruction.
REQ-007 Port: i_valid  input  1  incoming MEM/WB entry is a real instruction.
REQ-008 Port: i_reg_write  input  1  instruction writes the register file.
REQ-009 Port: i_wb_sel  input  2  writeback source: 00=ALU, 01=memory, 10=link, 11=ALU.
REQ-010 Port: i_mem_size  input  2  load size: 00=byte, 01=halfword, 10 or 11=word.
REQ-011 Port: i_mem_unsigned  input  1  1=zero-extend, 0=sign-extend sub-word loads.
REQ-012 Port: i_addr_lo  input  2  low two bits of the load address.
REQ-013 Port: i_alu_result  input  BUS_WIDTH  ALU result.
REQ-014 Port: i_mem_result  input  BUS_WIDTH  full aligned word from data memory.
REQ-015 Port: i_pc_plus8  input  BUS_WIDTH  link address.
REQ-016 Port: i_rd  input  REG_ADDR_WIDTH  destination register.
REQ-017 Port: o_wb_data  output  BUS_WIDTH  data to the register file and forwarding unit.
REQ-018 Port: o_wb_reg  output  REG_ADDR_WIDTH  destination register.
REQ-019 Port: o_wb_write  output  1  register-file write enable.
REQ-020 Port: o_wb_valid  output  1  stage holds a valid instruction.
REQ-021 Port: o_retired_count  output  32  count of retired instructions, for the debug unit.

Function
REQ-022 Each rising edge SHALL apply exactly one action, in this priority: i_reset, then i_flush, then i_halt, then load.
- i_flush=1: the stored valid bit and write bit SHALL be cleared; the remaining fields are don't-care.
- i_halt=1 (no flush): all stored fields and the counter SHALL hold.
- Load: all inputs SHALL be captured into the stage register.
REQ-023 Latency SHALL be 1 cycle: every output is driven combinationally from stored fields only, with no combinational path from any input to any output.
REQ-024 Load extraction SHALL be little-endian.
- Byte: lane i_addr_lo, i.e. bits [8k+7:8k] with k = i_addr_lo.
- Halfword: lane i_addr_lo[1], i.e. bits [16h+15:16h] with h = i_addr_lo[1]; i_addr_lo[0] is ignored.
- Word: the full word; i_addr_lo is ignored.
REQ-025 A sub-word load SHALL be extended to BUS_WIDTH: sign-extended when i_mem_unsigned=0, zero-extended when 1.
REQ-026 o_wb_data SHALL be the stored ALU result, the extracted memory value, or the stored pc+8, per the stored i_wb_sel; o_wb_data SHALL be 0 whenever o_wb_valid=0.
REQ-027 o_wb_write SHALL be stored_valid AND stored_reg_write AND (stored_rd != 0); writes to register 0 are suppressed.
REQ-028 o_retired_count SHALL increment by 1 on each load edge with i_valid=1, regardless of i_reg_write or i_rd. It SHALL NOT increment on flush, halt or reset edges, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-029 Simultaneous i_flush and i_halt SHALL produce a bubble (flush wins) and SHALL NOT increment the counter.
REQ-030 Back-to-back loads SHALL sustain one instruction per cycle with no dead cycles.

Reset
REQ-031 While i_reset=1 at a rising edge, all stored fields and o_retired_count SHALL become 0.
- Outputs after that edge: o_wb_data=0, o_wb_reg=0, o_wb_write=0, o_wb_valid=0.
REQ-032 Reset asserted mid-operation SHALL discard the stored instruction and override a simultaneous i_flush or i_halt.
REQ-033 The first load edge after reset deassertion SHALL capture inputs normally.

Verification
REQ-034 ALU path: after reset, load valid=1, reg_write=1, sel=00, alu=0x12345678, rd=3 -> next cycle o_wb_data=0x12345678, o_wb_reg=3, o_wb_write=1, o_wb_valid=1, count=1.
REQ-035 Byte loads from mem=0x87654321, sel=01, size=00:
- addr_lo=3, signed -> 0xFFFFFF87.
- addr_lo=3, unsigned -> 0x00000087.
- addr_lo=0, signed -> 0x00000021.
REQ-036 Halfword loads from mem=0x87654321, size=01:
- addr_lo=2, signed -> 0xFFFF8765.
- addr_lo=2, unsigned -> 0x00008765.
- addr_lo=0, signed -> 0x00004321.
REQ-037 Link path: sel=10, pc_plus8=0x00000048, rd=31 -> o_wb_data=0x00000048, o_wb_write=1.
REQ-038 Register 0: valid=1, reg_write=1, rd=0 -> o_wb_write=0, o_wb_valid=1, count incremented.
REQ-039 Stall, flush and reset:
- halt=1 for 3 cycles while inputs toggle -> outputs and count frozen.
- halt=1 with flush=1 -> o_wb_valid=0, o_wb_data=0, count unchanged.
- reset mid-stream -> all outputs 0 and count=0 on the next cycle.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM/WB boundary bundle: pipeline-side inputs of the writeback stage and its
// register-file / forwarding outputs.
interface wb_stage_if #(
    parameter int BUS_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      i_halt;
    logic                      i_flush;
    logic                      i_valid;
    logic                      i_reg_write;
    logic [1:0]                i_wb_sel;
    logic [1:0]                i_mem_size;
    logic                      i_mem_unsigned;
    logic [1:0]                i_addr_lo;
    logic [BUS_WIDTH-1:0]      i_alu_result;
    logic [BUS_WIDTH-1:0]      i_mem_result;
    logic [BUS_WIDTH-1:0]      i_pc_plus8;
    logic [REG_ADDR_WIDTH-1:0] i_rd;

    logic [BUS_WIDTH-1:0]      o_wb_data;
    logic [REG_ADDR_WIDTH-1:0] o_wb_reg;
    logic                      o_wb_write;
    logic                      o_wb_valid;
    logic [31:0]               o_retired_count;

    modport master (
        output i_halt, i_flush, i_valid, i_reg_write, i_wb_sel, i_mem_size,
               i_mem_unsigned, i_addr_lo, i_alu_result, i_mem_result,
               i_pc_plus8, i_rd,
        input  o_wb_data, o_wb_reg, o_wb_write, o_wb_valid, o_retired_count
    );

    modport slave (
        input  i_halt, i_flush, i_valid, i_reg_write, i_wb_sel, i_mem_size,
               i_mem_unsigned, i_addr_lo, i_alu_result, i_mem_result,
               i_pc_plus8, i_rd,
        output o_wb_data, o_wb_reg, o_wb_write, o_wb_valid, o_retired_count
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback pipeline stage: selects and aligns the result on the way into the
// stage register, so every output comes straight from a flop.
module wb_stage #(
    parameter int BUS_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic      i_clk,
    input  logic      i_reset,
    wb_stage_if.slave bus
);

    // Little-endian lane pick plus sign/zero extension of a sub-word load.
    function automatic logic [BUS_WIDTH-1:0] extract_load(
        input logic [BUS_WIDTH-1:0] word,
        input logic [1:0]           size,
        input logic                 is_unsigned,
        input logic [1:0]           addr_lo
    );
        logic [BUS_WIDTH-1:0] lane_s;
        logic [BUS_WIDTH-1:0] res_s;
        lane_s = {BUS_WIDTH{1'b0}};
        res_s  = word;
        case (size)
            2'b00: begin
                lane_s = word >> {addr_lo, 3'b000};
                if (is_unsigned) begin
                    res_s = BUS_WIDTH'(lane_s[7:0]);
                end else begin
                    res_s = BUS_WIDTH'($signed(lane_s[7:0]));
                end
            end
            2'b01: begin
                lane_s = word >> {addr_lo[1], 4'b0000};
                if (is_unsigned) begin
                    res_s = BUS_WIDTH'(lane_s[15:0]);
                end else begin
                    res_s = BUS_WIDTH'($signed(lane_s[15:0]));
                end
            end
            default: begin
                res_s = word;
            end
        endcase
        return res_s;
    endfunction

    // Writeback source mux; 2'b11 aliases the ALU path.
    function automatic logic [BUS_WIDTH-1:0] select_wb(
        input logic [1:0]           sel,
        input logic [BUS_WIDTH-1:0] alu,
        input logic [BUS_WIDTH-1:0] mem,
        input logic [BUS_WIDTH-1:0] link
    );
        logic [BUS_WIDTH-1:0] res_s;
        case (sel)
            2'b01:   res_s = mem;
            2'b10:   res_s = link;
            default: res_s = alu;
        endcase
        return res_s;
    endfunction

    logic                      valid_q, valid_d;
    logic                      write_q, write_d;
    logic [REG_ADDR_WIDTH-1:0] reg_q,   reg_d;
    logic [BUS_WIDTH-1:0]      data_q,  data_d;
    logic [31:0]               count_q, count_d;

    logic [BUS_WIDTH-1:0]      mem_val_s;
    logic [BUS_WIDTH-1:0]      sel_val_s;

    // Next-state: flush beats halt beats load; reset is handled in the flop block.
    always_comb begin
        valid_d   = valid_q;
        write_d   = write_q;
        reg_d     = reg_q;
        data_d    = data_q;
        count_d   = count_q;
        mem_val_s = extract_load(bus.i_mem_result, bus.i_mem_size,
                                 bus.i_mem_unsigned, bus.i_addr_lo);
        sel_val_s = select_wb(bus.i_wb_sel, bus.i_alu_result, mem_val_s,
                              bus.i_pc_plus8);
        if (bus.i_flush) begin
            // Data is zeroed too so an empty stage never drives stale data.
            valid_d = 1'b0;
            write_d = 1'b0;
            data_d  = {BUS_WIDTH{1'b0}};
        end else if (bus.i_halt) begin
            valid_d = valid_q;
            write_d = write_q;
            reg_d   = reg_q;
            data_d  = data_q;
            count_d = count_q;
        end else begin
            valid_d = bus.i_valid;
            reg_d   = bus.i_rd;
            write_d = bus.i_valid & bus.i_reg_write &
                      (bus.i_rd != {REG_ADDR_WIDTH{1'b0}});
            if (bus.i_valid) begin
                data_d  = sel_val_s;
                count_d = count_q + 32'd1;
            end else begin
                data_d  = {BUS_WIDTH{1'b0}};
                count_d = count_q;
            end
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            reg_q   <= {REG_ADDR_WIDTH{1'b0}};
            data_q  <= {BUS_WIDTH{1'b0}};
            count_q <= 32'd0;
        end else begin
            valid_q <= valid_d;
            write_q <= write_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign bus.o_wb_data       = data_q;
    assign bus.o_wb_reg        = reg_q;
    assign bus.o_wb_write      = write_q;
    assign bus.o_wb_valid      = valid_q;
    assign bus.o_retired_count = count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a behavioural model.
module tb_wb_stage;

    logic i_clk;
    logic i_reset;

    wb_stage_if #(.BUS_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    wb_stage #(.BUS_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model state
    logic [31:0] exp_data;
    logic [4:0]  exp_reg;
    logic        exp_reg_known;
    logic        exp_write;
    logic        exp_valid;
    logic [31:0] exp_count;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] mem, input logic [1:0] size,
                                               input logic uns, input logic [1:0] addr);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (mem >> (32'(addr) * 8)) & 32'h0000_00FF;
            if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (mem >> (32'(addr / 2) * 16)) & 32'h0000_FFFF;
            if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = mem;
        end
        return v;
    endfunction

    task automatic model_edge();
        if (i_reset) begin
            exp_data = 32'd0; exp_reg = 5'd0; exp_reg_known = 1'b1;
            exp_write = 1'b0; exp_valid = 1'b0; exp_count = 32'd0;
        end else if (bus.i_flush) begin
            exp_data = 32'd0; exp_write = 1'b0; exp_valid = 1'b0; exp_reg_known = 1'b0;
        end else if (!bus.i_halt) begin
            exp_valid = bus.i_valid;
            exp_reg = bus.i_rd; exp_reg_known = 1'b1;
            exp_write = bus.i_valid && bus.i_reg_write && (bus.i_rd != 5'd0);
            if (!bus.i_valid)            exp_data = 32'd0;
            else if (bus.i_wb_sel == 2'd1) exp_data = model_load(bus.i_mem_result, bus.i_mem_size,
                                                                 bus.i_mem_unsigned, bus.i_addr_lo);
            else if (bus.i_wb_sel == 2'd2) exp_data = bus.i_pc_plus8;
            else                           exp_data = bus.i_alu_result;
            if (bus.i_valid) exp_count = exp_count + 32'd1;
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".data"},  bus.o_wb_data, exp_data);
        check_val({tag, ".valid"}, 32'(bus.o_wb_valid), 32'(exp_valid));
        check_val({tag, ".write"}, 32'(bus.o_wb_write), 32'(exp_write));
        check_val({tag, ".count"}, bus.o_retired_count, exp_count);
        if (exp_reg_known) check_val({tag, ".reg"}, 32'(bus.o_wb_reg), 32'(exp_reg));
    endtask

    // One clock: model follows the edge, outputs sampled 1ns later.
    task automatic tick(input string tag);
        @(posedge i_clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                         input logic [1:0] size, input logic uns, input logic [1:0] addr,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc8, input logic [4:0] rd);
        bus.i_valid = v; bus.i_reg_write = rw; bus.i_wb_sel = sel;
        bus.i_mem_size = size; bus.i_mem_unsigned = uns; bus.i_addr_lo = addr;
        bus.i_alu_result = alu; bus.i_mem_result = mem; bus.i_pc_plus8 = pc8; bus.i_rd = rd;
    endtask

    task automatic drive_random();
        drive(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
              2'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
    endtask

    logic [31:0] snap_data;
    logic [31:0] snap_count;

    initial begin
        exp_data = 32'd0; exp_reg = 5'd0; exp_reg_known = 1'b0;
        exp_write = 1'b0; exp_valid = 1'b0; exp_count = 32'd0;
        i_reset = 1'b1; bus.i_halt = 1'b0; bus.i_flush = 1'b0;
        drive_random();
        tick("reset");
        tick("reset2");
        check_val("reset_data", bus.o_wb_data, 32'd0);
        check_val("reset_reg", 32'(bus.o_wb_reg), 32'd0);
        i_reset = 1'b0;

        // ALU path
        drive(1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 2'd0, 32'h1234_5678, 32'd0, 32'd0, 5'd3);
        tick("alu");
        check_val("alu_const", bus.o_wb_data, 32'h1234_5678);
        check_val("alu_count", bus.o_retired_count, 32'd1);

        // Byte and halfword loads
        drive(1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 2'd3, 32'd0, 32'h8765_4321, 32'd0, 5'd4);
        tick("lb3s");  check_val("lb3s_const", bus.o_wb_data, 32'hFFFF_FF87);
        bus.i_mem_unsigned = 1'b1;
        tick("lb3u");  check_val("lb3u_const", bus.o_wb_data, 32'h0000_0087);
        bus.i_mem_unsigned = 1'b0; bus.i_addr_lo = 2'd0;
        tick("lb0s");  check_val("lb0s_const", bus.o_wb_data, 32'h0000_0021);
        bus.i_mem_size = 2'b01; bus.i_addr_lo = 2'd2;
        tick("lh2s");  check_val("lh2s_const", bus.o_wb_data, 32'hFFFF_8765);
        bus.i_mem_unsigned = 1'b1;
        tick("lh2u");  check_val("lh2u_const", bus.o_wb_data, 32'h0000_8765);
        bus.i_mem_unsigned = 1'b0; bus.i_addr_lo = 2'd1;
        tick("lh1s");  check_val("lh1s_const", bus.o_wb_data, 32'h0000_4321);

        // Link path and register 0
        drive(1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'h0000_0048, 5'd31);
        tick("link");  check_val("link_const", bus.o_wb_data, 32'h0000_0048);
        drive(1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 2'd0, 32'h0000_0001, 32'd0, 32'd0, 5'd0);
        tick("r0");    check_val("r0_write", 32'(bus.o_wb_write), 32'd0);
        check_val("r0_count", bus.o_retired_count, 32'd9);

        // Halt for 3 cycles while inputs toggle
        snap_data = bus.o_wb_data; snap_count = bus.o_retired_count;
        bus.i_halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            tick("halt");
            check_val("halt_data", bus.o_wb_data, snap_data);
            check_val("halt_count", bus.o_retired_count, snap_count);
        end
        bus.i_flush = 1'b1; bus.i_valid = 1'b1;
        tick("halt_flush");
        check_val("hf_valid", 32'(bus.o_wb_valid), 32'd0);
        check_val("hf_data", bus.o_wb_data, 32'd0);
        check_val("hf_count", bus.o_retired_count, snap_count);
        bus.i_halt = 1'b0; bus.i_flush = 1'b0;

        // Reset mid-stream overriding halt
        drive(1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 2'd0, 32'h0000_0055, 32'd0, 32'd0, 5'd7);
        tick("pre_rst");
        i_reset = 1'b1; bus.i_halt = 1'b1;
        tick("mid_rst");
        check_val("mid_rst_count", bus.o_retired_count, 32'd0);
        i_reset = 1'b0; bus.i_halt = 1'b0;
        tick("post_rst");
        check_val("post_rst_count", bus.o_retired_count, 32'd1);

        // Randomized stream with occasional halt / flush / reset
        for (int i = 0; i < 400; i++) begin
            drive_random();
            bus.i_halt  = ($urandom_range(0, 5) == 0);
            bus.i_flush = ($urandom_range(0, 7) == 0);
            i_reset     = ($urandom_range(0, 63) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
